uart_rx_deser: RTL
==================

// Module: uart_rx_deser
// PURPOSE
//  8N1 UART receiver, the receive end of the serial link whose transmit side lives in the design.
//  Samples an asynchronous rx line and deserialises LSB-first bytes.
//  Presents each byte on a valid/ready output with a one-byte holding register.
//  Flags framing errors and overrun. Sits between the rx pin on ui_in and the command decoder.
// PARAMETERS
//  CLKS_PER_BIT  1042  clk cycles per bit period (10 MHz / 9600 baud); legal minimum 8
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous reset, active high
//  rx          in   1  asynchronous serial input, idle high
//  rx_data     out  8  received byte, valid while rx_valid=1
//  rx_valid    out  1  byte available; held until rx_ready handshake
//  rx_ready    in   1  consumer accepts byte when rx_valid&rx_ready at a rising edge
//  busy        out  1  1 whenever state != IDLE
//  frame_err   out  1  one-cycle pulse: stop bit sampled 0
//  overrun     out  1  sticky: a completed byte was dropped; cleared only by rst
//  parity_err  out  1  one-cycle pulse on parity mismatch; constant 0 without macro
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0, parity_err=0.
//    Reset sets both synchroniser flops to 1 and the FSM to IDLE; counters go to 0.
//  - rx passes through 2-flop synchroniser (rx_s); all decisions use rx_s.
//  - FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
//    - IDLE: rx_s=0 -> START, bit counter cleared.
//    - START: at count CLKS_PER_BIT/2-1, sample rx_s. A 1 is a glitch -> IDLE, no flags. A 0 -> DATA.
//    - DATA: sample every CLKS_PER_BIT cycles (mid-bit), shift in LSB first; after bit 7 -> STOP, or PARITY with macro.
//    - STOP: sample mid stop bit.
//      - 1 -> deliver byte, -> IDLE in the same cycle, so back-to-back frames are supported.
//      - 0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
//    - WAIT_HIGH: stay until rx_s=1, then -> IDLE. A held-low line/break yields exactly one frame_err.
//  - Delivery, in the cycle after the stop-bit sample:
//    - rx_valid=0, or rx_valid&rx_ready in that same cycle: load rx_data, rx_valid=1.
//    - Otherwise the new byte is dropped, rx_data is unchanged, and overrun<=1.
//  - rx_valid falls in the cycle after the rx_valid&rx_ready edge unless a new byte loads on that edge.
//  - Latency: rx_valid rises 1 cycle after the stop-bit mid-sample.
//    That is 9.5 bit periods + 3 cycles after the rx falling edge; 10.5 bit periods with parity.
//  - Bit counter is clog2(CLKS_PER_BIT) wide and resets to 0 at each sample point; no wrap beyond CLKS_PER_BIT-1.
//  - rst mid-frame: partial byte is discarded, any held rx_data is lost, and the FSM goes to IDLE.
//    If rx is low at that point, the FSM may restart on the next cycle.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - Frame is 8E1 and a PARITY state is sampled between DATA and STOP.
//    - Error condition: parity bit != XOR of the data bits (even parity).
//    - On error: parity_err pulses 1 cycle in the STOP-sample cycle and the byte is not delivered.
//    - If the stop bit is also 0, frame_err pulses too.
//  UART_RX_PARITY_EN undefined:
//    - Frame is 8N1, with no PARITY state.
//    - parity_err is tied to 0.
//  Port list identical in both builds.
// TESTING (bench CLKS_PER_BIT=8, rx_ready=1 unless stated)
//  1. Send 0xA5 8N1 -> rx_valid=1 for exactly 1 cycle with rx_data=0xA5; frame_err=overrun=0; busy=0 afterwards.
//  2. rx low for 3 cycles then high -> FSM returns to IDLE; no rx_valid, no flags.
//  3. Send 0x3C with stop bit 0, hold rx low 20 cycles, then release.
//     -> one frame_err pulse, no rx_valid; then send 0x55 -> rx_data=0x55 delivered.
//  4. rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, rx_valid=1, overrun=1.
//     Then rx_ready=1 -> one handshake; overrun remains 1.
//  5. Assert rst after 4 data bits of 0xF0 -> all outputs at reset values next cycle.
//     Then a full 0x7E frame -> rx_data=0x7E delivered.
//  6. UART_RX_PARITY_EN: send 0x01 with parity bit 0 -> parity_err pulse, no rx_valid.
//     Send 0x01 with parity bit 1 -> rx_data=0x01 delivered.

Source files
------------

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receiver with a two-flop synchroniser and LSB-first deserialiser.
// The received byte is held in a single valid/ready output register.
// Framing errors pulse frame_err, and a dropped byte sets the sticky overrun flag.
// Define UART_RX_PARITY_EN for 8E1 frames with a checked parity bit.
// Without the macro the frame is 8N1 and parity_err is tied low.
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_clr;
    logic          shift_en;
    logic          deliver;
    logic          ferr_set;
`ifdef UART_RX_PARITY_EN
    logic          par_bit;
    logic          par_cap;
    logic          perr_set;
`endif

    // Two-flop synchroniser on the asynchronous line; idles high out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; every sample point also restarts the bit-period counter
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        deliver  = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap  = 1'b0;
        perr_set = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_nx = START;
            end
            START: begin
                // Re-check the line mid start bit so short low glitches are ignored
                if (cnt == CNT_HALF) begin
                    cnt_clr  = 1'b1;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_FULL) begin
                    cnt_clr  = 1'b1;
                    par_cap  = 1'b1;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_clr  = 1'b1;
                    ferr_set = !rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_set = (par_bit != ^shreg);
                    deliver  = rx_s && (par_bit == ^shreg);
`else
                    deliver  = rx_s;
`endif
                    // Going straight to IDLE on a good stop bit lets the next start bit follow immediately
                    state_nx = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // A held-low line or break must not retrigger, so wait for the line to return high
                cnt_clr = 1'b1;
                if (rx_s) state_nx = IDLE;
            end
            default: begin
                cnt_clr  = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // Bit-period counter and data-bit index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state == IDLE)  bit_idx <= '0;
            else if (shift_en)  bit_idx <= bit_idx + 3'd1;
        end
    end

    // LSB-first shift register; its contents are only used once all eight bits are in
    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rx_s, shreg[7:1]};
    end

`ifdef UART_RX_PARITY_EN
    // Capture the parity bit for the check made at the stop-bit sample
    always_ff @(posedge clk) begin
        if (par_cap) par_bit <= rx_s;
    end

    // Parity error pulse, aligned with the stop-bit decision
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= perr_set;
    end
`else
    assign parity_err = 1'b0;
`endif

    // Output holding register: load when empty or draining this cycle, otherwise drop and flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else begin
                if (rx_valid && rx_ready) rx_valid <= 1'b0;
                if (deliver)              overrun  <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
